// File: rtl/alu_arbiter_seq_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter_seq.
// The master side drives the requests and the ALU results; the slave side is the arbiter.
interface alu_arbiter_seq_if #(
    parameter int W = 163
);
    logic [1:0]   req_valid;
    logic [1:0]   req_op0;
    logic [1:0]   req_op1;
    logic [W-1:0] req_a0;
    logic [W-1:0] req_b0;
    logic [W-1:0] req_a1;
    logic [W-1:0] req_b1;
    logic [1:0]   req_ready;

    logic         resp_valid;
    logic         resp_id;
    logic [W-1:0] resp_data;
    logic [W-1:0] resp_aux;
    logic         resp_err;

    logic [W-1:0] alu_DA;
    logic [W-1:0] alu_DB;
    logic         alu_Mul_enable;
    logic         alu_SQA_opt;
    logic [W-1:0] alu_BP_OUT1;
    logic [W-1:0] alu_BP_OUT2;
    logic [W-1:0] alu_SS_OUT;
    logic         alu_done;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output alu_BP_OUT1, alu_BP_OUT2, alu_SS_OUT, alu_done,
        input  req_ready, resp_valid, resp_id, resp_data, resp_aux, resp_err,
        input  alu_DA, alu_DB, alu_Mul_enable, alu_SQA_opt
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  alu_BP_OUT1, alu_BP_OUT2, alu_SS_OUT, alu_done,
        output req_ready, resp_valid, resp_id, resp_data, resp_aux, resp_err,
        output alu_DA, alu_DB, alu_Mul_enable, alu_SQA_opt
    );
endinterface

// File: rtl/alu_arbiter_seq.sv
// Two-requester round-robin front end for a shared handshake ALU, with a
// cycle watchdog that turns a stalled ALU into an error response.
module alu_arbiter_seq #(
    parameter int W       = 163,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    alu_arbiter_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SYNC, WAIT, RESP} state_t;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_MUL   = 2'b01;
    localparam logic [1:0] OP_SQADD = 2'b10;
    localparam logic [7:0] WD_LAST  = 8'(TIMEOUT - 1);

    state_t       state_reg, state_next;
    logic         last_reg, last_next;
    logic         id_reg, id_next;
    logic [1:0]   op_reg, op_next;
    logic [W-1:0] a_reg, a_next;
    logic [W-1:0] b_reg, b_next;
    logic [7:0]   wd_reg, wd_next;
    logic         resp_valid_reg, resp_valid_next;
    logic         resp_id_reg, resp_id_next;
    logic         resp_err_reg, resp_err_next;
    logic [W-1:0] resp_data_reg, resp_data_next;
    logic [W-1:0] resp_aux_reg, resp_aux_next;

    logic         gnt;
    logic [1:0]   op_sel;
    logic [1:0]   ready_vec;
    logic         wd_expired;

    // Under contention the requester that was not served last wins.
    assign gnt        = (bus.req_valid == 2'b11) ? ~last_reg : bus.req_valid[1];
    assign op_sel     = gnt ? bus.req_op1 : bus.req_op0;
    assign wd_expired = (wd_reg == WD_LAST);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign ready_vec[gi] = (state_reg == IDLE) && bus.req_valid[gi] && (gnt == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        id_next         = id_reg;
        op_next         = op_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        wd_next         = wd_reg;
        resp_valid_next = 1'b0;
        resp_id_next    = resp_id_reg;
        resp_err_next   = resp_err_reg;
        resp_data_next  = resp_data_reg;
        resp_aux_next   = resp_aux_reg;

        case (state_reg)
            IDLE: begin
                if (|ready_vec) begin
                    state_next = SYNC;
                    last_next  = gnt;
                    id_next    = gnt;
                    op_next    = (op_sel == 2'b11) ? OP_ADD : op_sel;
                    a_next     = gnt ? bus.req_a1 : bus.req_a0;
                    b_next     = gnt ? bus.req_b1 : bus.req_b0;
                    wd_next    = 8'd0;
                end
            end
            SYNC: begin
                wd_next = wd_reg + 8'd1;
                if (bus.alu_done) begin
                    state_next = WAIT;
                end else if (wd_expired) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_id_next    = id_reg;
                    resp_err_next   = 1'b1;
                    resp_data_next  = '0;
                    resp_aux_next   = '0;
                end
            end
            WAIT: begin
                wd_next = wd_reg + 8'd1;
                // A done pulse wins over a simultaneous watchdog expiry.
                if (bus.alu_done) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_id_next    = id_reg;
                    resp_err_next   = 1'b0;
                    resp_data_next  = (op_reg == OP_SQADD) ? bus.alu_BP_OUT2 : bus.alu_BP_OUT1;
                    resp_aux_next   = (op_reg == OP_SQADD) ? bus.alu_SS_OUT : '0;
                end else if (wd_expired) begin
                    state_next      = RESP;
                    resp_valid_next = 1'b1;
                    resp_id_next    = id_reg;
                    resp_err_next   = 1'b1;
                    resp_data_next  = '0;
                    resp_aux_next   = '0;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            last_reg       <= 1'b1;
            id_reg         <= 1'b0;
            op_reg         <= OP_ADD;
            a_reg          <= '0;
            b_reg          <= '0;
            wd_reg         <= 8'd0;
            resp_valid_reg <= 1'b0;
            resp_id_reg    <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_data_reg  <= '0;
            resp_aux_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            id_reg         <= id_next;
            op_reg         <= op_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            wd_reg         <= wd_next;
            resp_valid_reg <= resp_valid_next;
            resp_id_reg    <= resp_id_next;
            resp_err_reg   <= resp_err_next;
            resp_data_reg  <= resp_data_next;
            resp_aux_reg   <= resp_aux_next;
        end
    end

    assign bus.req_ready      = ready_vec;
    assign bus.resp_valid     = resp_valid_reg;
    assign bus.resp_id        = resp_id_reg;
    assign bus.resp_err       = resp_err_reg;
    assign bus.resp_data      = resp_data_reg;
    assign bus.resp_aux       = resp_aux_reg;
    assign bus.alu_DA         = a_reg;
    assign bus.alu_DB         = b_reg;
    // Op flags are presented only while the ALU is sampling the command.
    assign bus.alu_Mul_enable = (state_reg == SYNC) && (op_reg == OP_MUL);
    assign bus.alu_SQA_opt    = (state_reg == SYNC) && (op_reg == OP_SQADD);
endmodule
